pll_ctrl: RTL and testbench

PLL_CTRL -- requirements
Module: pll_ctrl

---
 rtl/pll_ctrl_pkg.sv | 32 +++
 rtl/pll_ctrl_sync_2ff.sv | 37 +++
 rtl/pll_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pll_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pll_ctrl_pkg
//   Shared definitions for the DCM/PLL bring-up controller:
//     - parameter defaults for pll_ctrl
//     - FSM state encoding
//     - small constant helper used to size the shared cycle counter
// ---------------------------------------------------------------------------
package pll_ctrl_pkg;

    // Parameter defaults
    localparam int RST_CYCLES_DEF    = 3;
    localparam int LOCK_TIMEOUT_DEF  = 100000;
    localparam int STABLE_CYCLES_DEF = 1024;
    localparam int MAX_RETRIES_DEF   = 7;

    // FSM state encoding
    typedef enum logic [2:0] {
        ST_RESET_DCM = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_e;

    // Largest of three values; sizes the counter shared by all timed states.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_ctrl_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous bit into the clk domain.
//   Both flops clear asynchronously so a reset also flushes any stale
//   sampled value.
//
// Ports
//   clk    in   destination clock
//   rst_n  in   asynchronous active-low reset
//   d      in   asynchronous input bit
//   q      out  synchronized bit (2 clk edges of latency)
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_p0;
    logic sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            // stage 0: capture, may be metastable
            meta_p0 <= d;
            // stage 1: resolved value
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/pll_ctrl.sv
// ---------------------------------------------------------------------------
// pll_ctrl
//   Bring-up and supervision controller for a DCM. Pulses DCM RST, waits for
//   LOCKED, requires LOCKED to stay high for STABLE_CYCLES before releasing
//   the downstream reset, and restarts the DCM if lock or the input clock is
//   lost. Repeated lock timeouts end in a FAULT state that only restart_req
//   leaves.
//
// Parameters
//   RST_CYCLES     DCM RST pulse length in clk_in cycles (min 3)
//   LOCK_TIMEOUT   max clk_in cycles to wait for lock per attempt
//   STABLE_CYCLES  consecutive locked cycles required before release
//   MAX_RETRIES    timed-out attempts allowed before FAULT (max 255)
//
// Ports
//   clk_in       in   reference clock, the only clock of this block
//   resetn       in   asynchronous active-low reset
//   restart_req  in   single-cycle request to restart the sequence
//   dcm_locked   in   DCM LOCKED, asynchronous to clk_in
//   dcm_status   in   DCM STATUS[7:0]; bit1 CLKIN stopped, bit2 CLKFX stopped
//   dcm_rst      out  DCM RST, active-high
//   sys_resetn   out  active-low reset for pixel and SoC logic
//   clk_ok       out  high while in RUN
//   fault        out  high while in FAULT
//   retry_count  out  timed-out attempts since the last clear
//
// Build option
//   PLL_CTRL_CLKFX_MON_EN  when defined, a stopped CLKFX (dcm_status[2]) in
//                          STABLE or RUN is handled exactly like loss of lock.
//                          When undefined, dcm_status[2] is ignored and has no
//                          synchronizer.
// ---------------------------------------------------------------------------
module pll_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = RST_CYCLES_DEF,
    parameter int LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int MAX_RETRIES   = MAX_RETRIES_DEF
) (
    input  logic       clk_in,
    input  logic       resetn,
    input  logic       restart_req,
    input  logic       dcm_locked,
    input  logic [7:0] dcm_status,
    output logic       dcm_rst,
    output logic       sys_resetn,
    output logic       clk_ok,
    output logic       fault,
    output logic [7:0] retry_count
);

    // One counter serves every timed state, so it is sized for the largest.
    localparam int MAX_PARAM = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int CNT_W     = (MAX_PARAM > 1) ? $clog2(MAX_PARAM) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]       RETRY_LIMIT = 8'(MAX_RETRIES);

    pll_state_e       state;
    pll_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [7:0]       retry_nxt;
    logic             retry_evt;

    logic lk;           // synchronized dcm_locked
    logic cs;           // synchronized CLKIN-stopped
    logic fs;           // synchronized CLKFX-stopped (0 when monitor disabled)
    logic lost;         // lock considered lost in STABLE/RUN
    logic unused_status;

    // Counter never wraps: it holds at all-ones once reached.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // -----------------------------------------------------------------------
    // Synchronizers
    // -----------------------------------------------------------------------
    sync_2ff u_sync_lk (
        .clk   (clk_in),
        .rst_n (resetn),
        .d     (dcm_locked),
        .q     (lk)
    );

    sync_2ff u_sync_cs (
        .clk   (clk_in),
        .rst_n (resetn),
        .d     (dcm_status[1]),
        .q     (cs)
    );

`ifdef PLL_CTRL_CLKFX_MON_EN
    sync_2ff u_sync_fs (
        .clk   (clk_in),
        .rst_n (resetn),
        .d     (dcm_status[2]),
        .q     (fs)
    );

    assign unused_status = ^{dcm_status[7:3], dcm_status[0]};
`else
    assign fs            = 1'b0;
    assign unused_status = ^{dcm_status[7:2], dcm_status[0]};
`endif

    assign lost = ~lk | fs;

    // -----------------------------------------------------------------------
    // State, counter and retry register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_RESET_DCM;
            cnt         <= '0;
            retry_count <= 8'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            retry_count <= retry_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic and Moore output decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt_sat_inc(cnt);
        retry_nxt  = retry_count;
        retry_evt  = 1'b0;
        dcm_rst    = 1'b0;
        sys_resetn = 1'b0;
        clk_ok     = 1'b0;
        fault      = 1'b0;

        unique case (state)
            ST_RESET_DCM: begin
                dcm_rst = 1'b1;
                if (cnt == RST_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                end
            end

            ST_WAIT_LOCK: begin
                if (lk) begin
                    state_nxt = ST_STABLE;
                end else if (cs || (cnt == LOCK_LAST)) begin
                    retry_evt = 1'b1;
                end
            end

            ST_STABLE: begin
                // cnt holds the number of locked cycles already seen here,
                // so the current cycle completes the run at STABLE_LAST.
                if (lost) begin
                    retry_evt = 1'b1;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = ST_RUN;
                    retry_nxt = 8'd0;
                end
            end

            ST_RUN: begin
                sys_resetn = 1'b1;
                clk_ok     = 1'b1;
                // Losing the clock after a successful bring-up is not a
                // failed attempt, so the retry count is left untouched.
                if (lost || cs) begin
                    state_nxt = ST_RESET_DCM;
                end
            end

            ST_FAULT: begin
                dcm_rst = 1'b1;
                fault   = 1'b1;
            end

            default: begin
                state_nxt = ST_RESET_DCM;
            end
        endcase

        if (retry_evt) begin
            if (retry_count < RETRY_LIMIT) begin
                retry_nxt = retry_count + 8'd1;
                state_nxt = ST_RESET_DCM;
            end else begin
                state_nxt = ST_FAULT;
            end
        end

        // restart_req overrides every other decision of this cycle.
        if (restart_req) begin
            state_nxt = ST_RESET_DCM;
            retry_nxt = 8'd0;
        end

        // Every state starts timing from zero.
        if (restart_req || (state_nxt != state)) begin
            cnt_nxt = '0;
        end
    end

endmodule

// File: tb/tb_pll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_ctrl
//   Self-checking bench for pll_ctrl with RST_CYCLES=3, LOCK_TIMEOUT=16,
//   STABLE_CYCLES=8, MAX_RETRIES=2. Each scenario pushes the per-cycle
//   expected outputs {dcm_rst, sys_resetn, clk_ok, fault, retry_count} into a
//   queue, then drives stimulus just after each rising edge and compares the
//   popped expectation on the falling edge. Cycle 0 of a scenario is the cycle
//   that starts at its first rising edge.
// ---------------------------------------------------------------------------
module tb_pll_ctrl;

    logic       clk_in = 1'b0;
    logic       resetn;
    logic       restart_req;
    logic       dcm_locked;
    logic [7:0] dcm_status;
    logic       dcm_rst;
    logic       sys_resetn;
    logic       clk_ok;
    logic       fault;
    logic [7:0] retry_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] exp_q[$];

    pll_ctrl #(
        .RST_CYCLES    (3),
        .LOCK_TIMEOUT  (16),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .clk_in      (clk_in),
        .resetn      (resetn),
        .restart_req (restart_req),
        .dcm_locked  (dcm_locked),
        .dcm_status  (dcm_status),
        .dcm_rst     (dcm_rst),
        .sys_resetn  (sys_resetn),
        .clk_ok      (clk_ok),
        .fault       (fault),
        .retry_count (retry_count)
    );

    always #5 clk_in = ~clk_in;

    // Queue n identical expected cycles.
    task automatic push_exp(input int n, input logic dr, input logic sr,
                            input logic ok, input logic f, input logic [7:0] rc);
        for (int i = 0; i < n; i++) exp_q.push_back({dr, sr, ok, f, rc});
    endtask

    task automatic test_reset();
        int c;
        logic [11:0] e, got;
        push_exp(3, 1, 0, 0, 0, 8'd0);
        c = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk_in); #1;
            @(negedge clk_in);
            e = exp_q.pop_front();
            got = {dcm_rst, sys_resetn, clk_ok, fault, retry_count};
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL reset cyc %0d: got dr,sr,ok,f=%b rc=%0d required dr,sr,ok,f=%b rc=%0d",
                         c, got[11:8], got[7:0], e[11:8], e[7:0]);
            end
            c++;
        end
    endtask

    task automatic test_lock_sequence();
        int c;
        logic [11:0] e, got;
        push_exp(3,  1, 0, 0, 0, 8'd0);   // cycles 0-2 RST pulse
        push_exp(18, 0, 0, 0, 0, 8'd0);   // 3-12 WAIT_LOCK, 13-20 STABLE
        push_exp(4,  0, 1, 1, 0, 8'd0);   // 21-24 RUN
        c = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk_in); #1;
            if (c == 0)  resetn = 1'b1;
            if (c == 10) dcm_locked = 1'b1;
            @(negedge clk_in);
            e = exp_q.pop_front();
            got = {dcm_rst, sys_resetn, clk_ok, fault, retry_count};
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL lock_seq cyc %0d: got dr,sr,ok,f=%b rc=%0d required dr,sr,ok,f=%b rc=%0d",
                         c, got[11:8], got[7:0], e[11:8], e[7:0]);
            end
            c++;
        end
    endtask

    task automatic test_relock();
        int c;
        logic [11:0] e, got;
        push_exp(3, 0, 1, 1, 0, 8'd0);    // RUN until loss reaches the FSM
        push_exp(3, 1, 0, 0, 0, 8'd0);    // RST pulse
        push_exp(9, 0, 0, 0, 0, 8'd0);    // 1 WAIT_LOCK + 8 STABLE
        push_exp(3, 0, 1, 1, 0, 8'd0);    // RUN again
        c = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk_in); #1;
            if (c == 0) dcm_locked = 1'b0;
            if (c == 1) dcm_locked = 1'b1;
            @(negedge clk_in);
            e = exp_q.pop_front();
            got = {dcm_rst, sys_resetn, clk_ok, fault, retry_count};
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL relock cyc %0d: got dr,sr,ok,f=%b rc=%0d required dr,sr,ok,f=%b rc=%0d",
                         c, got[11:8], got[7:0], e[11:8], e[7:0]);
            end
            c++;
        end
    endtask

    task automatic test_clkin_stop();
        int c;
        logic [11:0] e, got;
        push_exp(3, 0, 1, 1, 0, 8'd0);
        push_exp(3, 1, 0, 0, 0, 8'd0);
        push_exp(9, 0, 0, 0, 0, 8'd0);
        push_exp(3, 0, 1, 1, 0, 8'd0);
        c = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk_in); #1;
            if (c == 0) dcm_status = 8'h02;
            if (c == 1) dcm_status = 8'h00;
            @(negedge clk_in);
            e = exp_q.pop_front();
            got = {dcm_rst, sys_resetn, clk_ok, fault, retry_count};
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL clkin_stop cyc %0d: got dr,sr,ok,f=%b rc=%0d required dr,sr,ok,f=%b rc=%0d",
                         c, got[11:8], got[7:0], e[11:8], e[7:0]);
            end
            c++;
        end
    endtask

    task automatic test_clkfx();
        int c;
        logic [11:0] e, got;
`ifdef PLL_CTRL_CLKFX_MON_EN
        push_exp(3, 0, 1, 1, 0, 8'd0);
        push_exp(3, 1, 0, 0, 0, 8'd0);
        push_exp(9, 0, 0, 0, 0, 8'd0);
        push_exp(3, 0, 1, 1, 0, 8'd0);
`else
        push_exp(18, 0, 1, 1, 0, 8'd0);   // CLKFX status ignored: stays in RUN
`endif
        c = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk_in); #1;
            if (c == 0) dcm_status = 8'h04;
            if (c == 1) dcm_status = 8'h00;
            @(negedge clk_in);
            e = exp_q.pop_front();
            got = {dcm_rst, sys_resetn, clk_ok, fault, retry_count};
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL clkfx cyc %0d: got dr,sr,ok,f=%b rc=%0d required dr,sr,ok,f=%b rc=%0d",
                         c, got[11:8], got[7:0], e[11:8], e[7:0]);
            end
            c++;
        end
    endtask

    task automatic test_timeout_fault();
        int c;
        logic [11:0] e, got;
        push_exp(3,  0, 1, 1, 0, 8'd0);   // RUN
        push_exp(3,  1, 0, 0, 0, 8'd0);   // RST, no retry counted from RUN
        push_exp(16, 0, 0, 0, 0, 8'd0);   // first wait
        push_exp(3,  1, 0, 0, 0, 8'd1);
        push_exp(16, 0, 0, 0, 0, 8'd1);   // second wait
        push_exp(3,  1, 0, 0, 0, 8'd2);
        push_exp(16, 0, 0, 0, 0, 8'd2);   // third wait
        push_exp(10, 1, 0, 0, 1, 8'd2);   // FAULT held
        c = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk_in); #1;
            if (c == 0) dcm_locked = 1'b0;
            @(negedge clk_in);
            e = exp_q.pop_front();
            got = {dcm_rst, sys_resetn, clk_ok, fault, retry_count};
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL timeout cyc %0d: got dr,sr,ok,f=%b rc=%0d required dr,sr,ok,f=%b rc=%0d",
                         c, got[11:8], got[7:0], e[11:8], e[7:0]);
            end
            c++;
        end
    endtask

    task automatic test_restart_from_fault();
        int c;
        logic [11:0] e, got;
        push_exp(1, 1, 0, 0, 1, 8'd2);    // still FAULT while request is seen
        push_exp(3, 1, 0, 0, 0, 8'd0);    // RST pulse, retries cleared
        push_exp(9, 0, 0, 0, 0, 8'd0);    // 1 WAIT_LOCK + 8 STABLE
        push_exp(3, 0, 1, 1, 0, 8'd0);
        c = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk_in); #1;
            if (c == 0) restart_req = 1'b1;
            if (c == 1) begin
                restart_req = 1'b0;
                dcm_locked  = 1'b1;
            end
            @(negedge clk_in);
            e = exp_q.pop_front();
            got = {dcm_rst, sys_resetn, clk_ok, fault, retry_count};
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL restart cyc %0d: got dr,sr,ok,f=%b rc=%0d required dr,sr,ok,f=%b rc=%0d",
                         c, got[11:8], got[7:0], e[11:8], e[7:0]);
            end
            c++;
        end
    endtask

    task automatic test_reset_in_stable();
        int c;
        logic [11:0] e, got;
        push_exp(1, 0, 1, 1, 0, 8'd0);    // RUN, restart requested
        push_exp(3, 1, 0, 0, 0, 8'd0);    // RST pulse
        push_exp(6, 0, 0, 0, 0, 8'd0);    // WAIT_LOCK + STABLE counts 0-4
        push_exp(6, 1, 0, 0, 0, 8'd0);    // reset at count 5, then RST pulse
        push_exp(9, 0, 0, 0, 0, 8'd0);
        push_exp(3, 0, 1, 1, 0, 8'd0);
        c = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk_in); #1;
            if (c == 0) restart_req = 1'b1;
            if (c == 1) restart_req = 1'b0;
            if (c == 10) begin
                resetn      = 1'b0;
                restart_req = 1'b1;
            end
            if (c == 13) begin
                resetn      = 1'b1;
                restart_req = 1'b0;
            end
            @(negedge clk_in);
            e = exp_q.pop_front();
            got = {dcm_rst, sys_resetn, clk_ok, fault, retry_count};
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL reset_stable cyc %0d: got dr,sr,ok,f=%b rc=%0d required dr,sr,ok,f=%b rc=%0d",
                         c, got[11:8], got[7:0], e[11:8], e[7:0]);
            end
            c++;
        end
    endtask

    initial begin
        resetn      = 1'b0;
        restart_req = 1'b0;
        dcm_locked  = 1'b0;
        dcm_status  = 8'h00;

        test_reset();
        test_lock_sequence();
        test_relock();
        test_clkin_stop();
        test_clkfx();
        test_timeout_fault();
        test_restart_from_fault();
        test_reset_in_stable();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
